// File: rtl/dev_port_fifo_if.sv
// Handshake bundle between the device-side writer and the bus-side reader
// of the port FIFO.
interface dev_port_fifo_if #(
    parameter int width = 16,
    parameter int depth = 8
);
    logic                       push;
    logic [width-1:0]           D_push;
    logic                       pop;
    logic [width-1:0]           D_pop;
    logic                       pndng;
    logic                       full;
    logic [$clog2(depth+1)-1:0] count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output push, D_push, pop,
        input  D_pop, pndng, full, count, overflow, underflow
    );

    modport slave (
        input  push, D_push, pop,
        output D_pop, pndng, full, count, overflow, underflow
    );
endinterface

// File: rtl/dev_port_fifo.sv
// First-word fall-through circular FIFO between a device driver and a bus,
// with registered occupancy and one-cycle overflow/underflow pulses.
module dev_port_fifo #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input logic            clk,
    input logic            rst_n,
    dev_port_fifo_if.slave bus
);
    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth + 1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    rd_ptr;
    logic [aw-1:0]    wr_ptr;
    logic [cw-1:0]    cnt;
    logic             ovf;
    logic             udf;
    logic             nonempty;
    logic             is_full;
    logic             do_push;
    logic             do_pop;

    assign nonempty = (cnt != '0);
    assign is_full  = (cnt == full_cnt);
    assign do_pop   = bus.pop && nonempty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign do_push  = bus.push && (!is_full || bus.pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + aw'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + aw'(1);
            unique case (1'b1)
                (do_push && !do_pop): cnt <= cnt + cw'(1);
                (do_pop && !do_push): cnt <= cnt - cw'(1);
                default: ;
            endcase
            ovf <= bus.push && is_full && !bus.pop;
            udf <= bus.pop && !nonempty;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst_n && do_push)
            mem[wr_ptr] <= bus.D_push;
    end

    assign bus.D_pop     = mem[rd_ptr];
    assign bus.pndng     = nonempty;
    assign bus.full      = is_full;
    assign bus.count     = cnt;
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;
endmodule

// File: tb/tb_dev_port_fifo.sv
// Self-checking bench for dev_port_fifo: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_dev_port_fifo;
    localparam int W = 16;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq [$];
    logic mo = 1'b0;
    logic mu = 1'b0;

    always #5 clk = ~clk;

    dev_port_fifo_if #(.width(W), .depth(D)) bus ();

    dev_port_fifo #(.width(W), .depth(D)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        chk({tag, ".pndng"}, 32'(bus.pndng), 32'(mq.size() != 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(mq.size() == D));
        chk({tag, ".overflow"}, 32'(bus.overflow), 32'(mo));
        chk({tag, ".underflow"}, 32'(bus.underflow), 32'(mu));
        if (mq.size() != 0)
            chk({tag, ".D_pop"}, 32'(bus.D_pop), 32'(mq[0]));
    endtask

    // One clock: drive at negedge, model the edge, check after it.
    task automatic step(input logic p, input logic [W-1:0] d,
                        input logic q, input string tag);
        int n;
        @(negedge clk);
        bus.push   = p;
        bus.D_push = d;
        bus.pop    = q;
        @(posedge clk);
        #1;
        n  = mq.size();
        mo = p && (n == D) && !q;
        mu = q && (n == 0);
        if (q && n != 0)
            void'(mq.pop_front());
        if (p && (n < D || q))
            mq.push_back(d);
        check_all(tag);
    endtask

    initial begin
        logic [W-1:0] v;
        int pp;
        int qp;
        bus.push   = 1'b0;
        bus.D_push = '0;
        bus.pop    = 1'b0;

        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0, "idle");

        // In-order fall-through readback
        step(1'b1, 16'h1111, 1'b0, "fifo3.push1");
        step(1'b1, 16'h2222, 1'b0, "fifo3.push2");
        step(1'b1, 16'h3333, 1'b0, "fifo3.push3");
        for (int i = 0; i < 3; i++)
            step(1'b0, '0, 1'b1, "fifo3.pop");

        // Fill past full
        for (int i = 1; i <= 9; i++)
            step(1'b1, W'(i), 1'b0, "fill9");
        step(1'b0, '0, 1'b0, "ovf.clear");
        for (int i = 0; i < 8; i++)
            step(1'b0, '0, 1'b1, "drain8");

        // Push+pop while full
        for (int i = 1; i <= 8; i++)
            step(1'b1, W'(16'h0100 + i), 1'b0, "refill");
        step(1'b1, 16'hAAAA, 1'b1, "full.pushpop");
        for (int i = 0; i < 8; i++)
            step(1'b0, '0, 1'b1, "drain.aaaa");
        chk("aaaa.last", 32'(bus.pndng), 32'(0));

        // Pop on empty with concurrent push
        step(1'b1, 16'hBEEF, 1'b1, "udf.beef");
        step(1'b0, '0, 1'b0, "udf.clear");
        step(1'b0, '0, 1'b1, "udf.drain");

        // Pointer wrap with steady-state push/pop pairs
        step(1'b1, 16'hC000, 1'b0, "wrap.seed");
        for (int i = 1; i <= 20; i++)
            step(1'b1, W'(16'hC000 + i), 1'b1, "wrap.pair");
        step(1'b0, '0, 1'b1, "wrap.drain");

        // Asynchronous reset in mid-operation
        for (int i = 0; i < 5; i++)
            step(1'b1, W'(16'hD000 + i), 1'b0, "pre.rst");
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        bus.push = 1'b1;
        bus.D_push = 16'hFFFF;
        #1;
        mq.delete();
        mo = 1'b0;
        mu = 1'b0;
        check_all("rst.async");
        @(posedge clk);
        #1;
        check_all("rst.held");
        @(negedge clk);
        rst_n    = 1'b1;
        bus.push = 1'b0;
        step(1'b1, 16'h5A5A, 1'b0, "rst.first");
        chk("rst.5a5a", 32'(bus.D_pop), 32'h5A5A);
        step(1'b0, '0, 1'b1, "rst.pop");

        // Random traffic in three bias phases
        for (int ph = 0; ph < 3; ph++) begin
            pp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            qp = 100 - pp;
            for (int i = 0; i < 150; i++) begin
                v = W'($urandom);
                step($urandom_range(0, 99) < pp, v,
                     $urandom_range(0, 99) < qp, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
